rv_adder: RTL and testbench
===========================

Name: rv_adder

Overview:
- 32-bit integer add/subtract block used for PC increment, branch-target and address arithmetic in the pipelined RISC-V core.
- Primary result `out` is purely combinational, so it can sit inside a single pipeline stage.
- An optional registered copy of the result and flags, with a valid strobe, serves stages that need a registered value.

Parameters:
- WIDTH, 32, operand and result width in bits; must be ≥ 2.

Ports:
- clk  input  1  Single system clock; all registers update on its rising edge.
- rst  input  1  Synchronous, active-high reset, sampled on the rising edge of clk.
- inp1  input  WIDTH  Operand A.
- inp2  input  WIDTH  Operand B.
- sub  input  1  0 = add, 1 = subtract (inp1 − inp2).
- in_valid  input  1  Qualifies the operands for capture into the output register.
- out  output  WIDTH  Combinational result.
- carry  output  1  Combinational carry-out of bit WIDTH−1.
- overflow  output  1  Combinational two's-complement signed overflow.
- zero  output  1  Combinational: 1 when out == 0.
- out_q  output  WIDTH  Registered result.
- flags_q  output  3  Registered {carry, overflow, zero}.
- out_valid  output  1  Registered in_valid; qualifies out_q and flags_q.

Behaviour:
- Combinational path, no clock dependency, settles within the same cycle:
  - b_eff = sub ? ~inp2 : inp2
  - {carry, out} = inp1 + b_eff + sub, computed as a (WIDTH+1)-bit sum.
- Result wraps modulo 2^WIDTH.
  - 0xFFFFFFFF + 1 gives out = 0, carry = 1.
- Subtract carry convention: carry = 1 means no borrow (inp1 ≥ inp2 unsigned); carry = 0 means borrow.
- overflow = (inp1[MSB] == b_eff[MSB]) && (out[MSB] != inp1[MSB]).
- zero = (out == 0).
- Combinational outputs are independent of rst and valid whenever the inputs are known, including during reset.
- Registered path, one-cycle latency:
  - At each rising edge with rst = 0: out_valid <= in_valid.
  - If in_valid = 1, also out_q <= out and flags_q <= {carry, overflow, zero}.
  - If in_valid = 0, out_q and flags_q hold their previous values.
- Reset: on a rising edge with rst = 1, out_q = 0, flags_q = 3'b000, out_valid = 0.
  - Reset takes priority over a simultaneous in_valid.
  - Reset asserted mid-stream drops the in-flight result; no stale out_valid afterwards.
  - The first valid result after reset appears one cycle after the first in_valid with rst = 0.
- No X-propagation masking: X on an operand may propagate to out.
- No handshake back-pressure: every in_valid is accepted.

Decomposition:
- Shared package rv_alu_pkg:
  - ADDER_WIDTH = 32.
  - Packed struct adder_flags_t {carry, overflow, zero}, with flags_q typed as this struct.
  - Localparam for the flag bit ordering.
- One natural sub-module, rv_adder_core:
  - Combinational: operand inversion, the (WIDTH+1)-bit sum, and flag generation.
  - Top-level rv_adder wraps it with the output register and valid pipeline.
- Core is reusable by the ALU and the branch unit.

Test Plan:
- inp1 = 0, inp2 = 0, sub = 0 → out = 0, zero = 1, carry = 0, overflow = 0; after the clock edge with in_valid = 1, out_q = 0, out_valid = 1.
- inp1 = 10, inp2 = 20, sub = 0 → out = 30 (0x1E), all flags 0; out_q = 30 exactly one cycle after in_valid.
- 0xFFFFFFFF + 0x00000001 → out = 0, carry = 1, zero = 1, overflow = 0.
- 0x7FFFFFFF + 0x00000001 → out = 0x80000000, overflow = 1, carry = 0.
- Subtraction cases:
  - sub = 1, 10 − 20 → out = 0xFFFFFFF6, carry = 0 (borrow), overflow = 0.
  - sub = 1, 20 − 20 → out = 0, carry = 1, zero = 1.
- Reset and valid control:
  - Stream of valid adds, then rst = 1 for one cycle with in_valid = 1 → next edge gives out_q = 0, flags_q = 0, out_valid = 0.
  - With in_valid = 0, out_q holds its last value and out_valid = 0.

Source files
------------

// File: rtl/rv_adder_pkg.sv
// Shared definitions for the integer adder and its users (ALU, branch unit).
package rv_alu_pkg;

    // Default datapath width of the core.
    localparam int unsigned ADDER_WIDTH = 32;

    // Bit positions of each flag inside the packed flag vector.
    localparam int unsigned FLAG_CARRY    = 2;
    localparam int unsigned FLAG_OVERFLOW = 1;
    localparam int unsigned FLAG_ZERO     = 0;
    localparam int unsigned FLAG_COUNT    = 3;

    // Operation select; the encoding matches the raw sub input.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } adder_op_t;

    // Flag bundle, MSB first: {carry, overflow, zero}.
    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } adder_flags_t;

    // Build a flag bundle from individual flag bits.
    function automatic adder_flags_t make_flags(input logic c, input logic v, input logic z);
        adder_flags_t f;
        f.carry    = c;
        f.overflow = v;
        f.zero     = z;
        return f;
    endfunction

endpackage

// File: rtl/rv_adder_if.sv
// Operand/result bundle of the adder; master drives operands, slave returns results.
interface rv_adder_if
    import rv_alu_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH
) ();

    logic [WIDTH-1:0] inp1;
    logic [WIDTH-1:0] inp2;
    logic             sub;
    logic             in_valid;

    logic [WIDTH-1:0] out;
    logic             carry;
    logic             overflow;
    logic             zero;

    logic [WIDTH-1:0] out_q;
    adder_flags_t     flags_q;
    logic             out_valid;

    modport master (
        output inp1, inp2, sub, in_valid,
        input  out, carry, overflow, zero,
        input  out_q, flags_q, out_valid
    );

    modport slave (
        input  inp1, inp2, sub, in_valid,
        output out, carry, overflow, zero,
        output out_q, flags_q, out_valid
    );

endinterface

// File: rtl/rv_adder_core.sv
// Purely combinational add/subtract with carry, signed overflow and zero flags.
module rv_adder_core
    import rv_alu_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH
) (
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    input  logic             sub,
    output logic [WIDTH-1:0] out,
    output adder_flags_t     flags
);

    adder_op_t        op;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // Subtraction is inp1 + ~inp2 + 1; carry-out of 1 therefore means no borrow.
    always_comb begin
        op    = adder_op_t'(sub);
        b_eff = (op == OP_SUB) ? ~inp2 : inp2;
        sum   = {1'b0, inp1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        out   = sum[WIDTH-1:0];
        flags = make_flags(sum[WIDTH],
                           (inp1[WIDTH-1] == b_eff[WIDTH-1]) &&
                           (sum[WIDTH-1] != inp1[WIDTH-1]),
                           (sum[WIDTH-1:0] == '0));
    end

endmodule

// File: rtl/rv_adder.sv
// Adder with combinational result/flags plus a one-cycle registered copy and valid strobe.
module rv_adder
    import rv_alu_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    rv_adder_if.slave    bus
);

    logic [WIDTH-1:0]      sum_out;
    adder_flags_t          sum_flags;
    logic [FLAG_COUNT-1:0] flag_bits;

    logic [WIDTH-1:0]      out_r;
    adder_flags_t          flags_r;
    logic                  valid_r;

    rv_adder_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .inp1  (bus.inp1),
        .inp2  (bus.inp2),
        .sub   (bus.sub),
        .out   (sum_out),
        .flags (sum_flags)
    );

    // Expose the combinational result and split the flag bundle into scalars.
    always_comb begin
        flag_bits    = sum_flags;
        bus.out      = sum_out;
        bus.carry    = flag_bits[FLAG_CARRY];
        bus.overflow = flag_bits[FLAG_OVERFLOW];
        bus.zero     = flag_bits[FLAG_ZERO];
    end

    // Capture result on in_valid, hold otherwise; reset wins over a same-cycle in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r   <= '0;
            flags_r <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                out_r   <= sum_out;
                flags_r <= sum_flags;
            end
        end
    end

    // Drive registered outputs onto the bus.
    always_comb begin
        bus.out_q     = out_r;
        bus.flags_q   = flags_r;
        bus.out_valid = valid_r;
    end

endmodule

// File: tb/tb_rv_adder.sv
// Directed self-checking bench for rv_adder: vector table plus reset/hold sequences.
module tb_rv_adder;
    import rv_alu_pkg::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;

    rv_adder_if #(.WIDTH(W)) bus ();

    rv_adder #(.WIDTH(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] exp_out;
        logic        exp_c;
        logic        exp_v;
        logic        exp_z;
    } vec_t;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s, input logic v);
        bus.inp1     = a;
        bus.inp2     = b;
        bus.sub      = s;
        bus.in_valid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[9];
    logic [31:0] last_out;
    logic [2:0]  last_flags;

    initial begin
        vecs[0] = '{"zero_add",  32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{"add_10_20", 32'd10,        32'd20,        1'b0, 32'h0000_001E, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{"wrap_add",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{"pos_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{"sub_10_20", 32'd10,        32'd20,        1'b1, 32'hFFFF_FFF6, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"sub_20_20", 32'd20,        32'd20,        1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{"neg_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{"sub_0_1",   32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{"min_plus",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};

        // Reset with operands applied: registers clear, combinational path still live.
        rst = 1'b1;
        drive(32'd3, 32'd4, 1'b0, 1'b1);
        tick();
        tick();
        check("rst_out_q",      64'(bus.out_q), 64'h0);
        check("rst_flags_q",    64'(bus.flags_q), 64'h0);
        check("rst_out_valid",  64'(bus.out_valid), 64'h0);
        check("rst_comb_out",   64'(bus.out), 64'd7);

        rst = 1'b0;
        drive(32'd3, 32'd4, 1'b0, 1'b0);
        tick();
        check("idle_out_valid", 64'(bus.out_valid), 64'h0);

        // Table-driven vectors: combinational check, then registered copy one edge later.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].s, 1'b1);
            #1;
            check({vecs[i].name, "_out"},   64'(bus.out), 64'(vecs[i].exp_out));
            check({vecs[i].name, "_flags"}, 64'({bus.carry, bus.overflow, bus.zero}),
                  64'({vecs[i].exp_c, vecs[i].exp_v, vecs[i].exp_z}));
            tick();
            check({vecs[i].name, "_out_q"},     64'(bus.out_q), 64'(vecs[i].exp_out));
            check({vecs[i].name, "_flags_q"},   64'(bus.flags_q),
                  64'({vecs[i].exp_c, vecs[i].exp_v, vecs[i].exp_z}));
            check({vecs[i].name, "_out_valid"}, 64'(bus.out_valid), 64'h1);
        end
        last_out   = vecs[8].exp_out;
        last_flags = {vecs[8].exp_c, vecs[8].exp_v, vecs[8].exp_z};

        // in_valid low: registers hold even though operands change.
        drive(32'd1, 32'd1, 1'b0, 1'b0);
        tick();
        check("hold_out_q",     64'(bus.out_q), 64'(last_out));
        check("hold_flags_q",   64'(bus.flags_q), 64'(last_flags));
        check("hold_out_valid", 64'(bus.out_valid), 64'h0);
        check("hold_comb_out",  64'(bus.out), 64'd2);

        // Mid-stream reset with in_valid high drops the in-flight result.
        drive(32'd5, 32'd6, 1'b0, 1'b1);
        tick();
        check("pre_rst_out_q", 64'(bus.out_q), 64'd11);
        rst = 1'b1;
        drive(32'd100, 32'd200, 1'b0, 1'b1);
        tick();
        check("mid_rst_out_q",     64'(bus.out_q), 64'h0);
        check("mid_rst_flags_q",   64'(bus.flags_q), 64'h0);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'h0);
        rst = 1'b0;
        drive(32'd100, 32'd200, 1'b0, 1'b0);
        tick();
        check("post_rst_no_stale", 64'(bus.out_valid), 64'h0);

        // First valid after reset: visible exactly one edge after in_valid.
        drive(32'd1, 32'd2, 1'b0, 1'b1);
        #1;
        check("first_pre_valid", 64'(bus.out_valid), 64'h0);
        check("first_pre_out_q", 64'(bus.out_q), 64'h0);
        tick();
        check("first_out_q",     64'(bus.out_q), 64'd3);
        check("first_out_valid", 64'(bus.out_valid), 64'h1);
        drive(32'd1, 32'd2, 1'b0, 1'b0);
        tick();
        check("first_valid_drop", 64'(bus.out_valid), 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
